fifo_umbral: RTL and testbench

Synchronous single-clock FIFO with runtime-programmable almost-full and almost-empty thresholds. One instance per port (P0..P3) feeds the round-robin arbiter stage directly downstream. It supplies the empty and almost_full flags that the arbiter qualifies on, and accepts the arbiter's pop. The same block is instantiated on the arbiter output side, where it is driven by push.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 40 ++++
 rtl/fifo_umbral.sv | 112 +++++++++++
 tb/tb_fifo_umbral.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the per-port FIFOs and the arbiter/demux stages that
// consume the packed word layout.
package fifo_pkg;

    localparam int FIFO_DATA_W = 10;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_ADDR_W = 3;

    // Packed word layout: dest [9:8], class [7:6], payload [5:0]
    localparam int DEST_HI    = 9;
    localparam int DEST_LO    = 8;
    localparam int CLASS_HI   = 7;
    localparam int CLASS_LO   = 6;
    localparam int PAYLOAD_HI = 5;
    localparam int PAYLOAD_LO = 0;

    typedef struct packed {
        logic [DEST_HI-DEST_LO:0]       dest;
        logic [CLASS_HI-CLASS_LO:0]     cls;
        logic [PAYLOAD_HI-PAYLOAD_LO:0] payload;
    } fifo_word_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array: one synchronous write port and one registered
// read port. Only the read register is reset; the array itself is not.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read samples the pre-edge contents, so a same-slot write returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERR_EN to add sticky overflow/underflow outputs.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [ADDR_W:0]   th_af,
    input  logic [ADDR_W:0]   th_ae,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef FIFO_ERR_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   fill_count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q;
    logic              pop_ok, push_ok;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_COUNT);
    assign almost_full  = (count_q >= th_af);
    assign almost_empty = (count_q <= th_ae);
    assign fill_count   = count_q;
    assign valid_out    = valid_q;

    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= pop_ok;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (push & full & ~pop_ok);
            underflow_q <= underflow_q | (pop & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok & reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_ok & reset),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: a reference occupancy model plus a
// queue of expected read words; each scenario task compares DUT outputs inline.
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [9:0] data_in = '0;
    logic       pop = 1'b0;
    logic [9:0] data_out;
    logic       valid_out;
    logic [3:0] th_af = 4'd6;
    logic [3:0] th_ae = 4'd2;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] fill_count;
`ifdef FIFO_ERR_EN
    logic       overflow, underflow;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
`endif

    int         n_checks = 0;
    int         n_pass = 0;

    logic [9:0] sb[$];
    int         m_cnt = 0;
    logic       exp_valid = 1'b0;
    logic [9:0] exp_data = '0;

    always #5 clk = ~clk;

    fifo_umbral dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .th_af        (th_af),
        .th_ae        (th_ae),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .fill_count   (fill_count)
    );

    // Drive one cycle of requests, advance the clock, update the reference model.
    task automatic cycle(input logic p, input logic [9:0] d, input logic q);
        logic m_pop, m_push;
        push = p; data_in = d; pop = q;
        m_pop  = q && (m_cnt != 0);
        m_push = p && ((m_cnt != 8) || m_pop);
`ifdef FIFO_ERR_EN
        if (p && m_cnt == 8 && !m_pop) m_ovf = 1'b1;
        if (q && m_cnt == 0) m_udf = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (m_pop) exp_data = sb.pop_front();
        exp_valid = m_pop;
        if (m_push) sb.push_back(d);
        m_cnt = sb.size();
        push = 1'b0; pop = 1'b0;
        $display("cycle push=%0b din=%03h pop=%0b -> valid=%0b dout=%03h count=%0d", p, d, q, valid_out, data_out, fill_count);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0; push = 1'b1; pop = 1'b1; data_in = 10'h3C3;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1; push = 1'b0; pop = 1'b0;
        sb.delete();
        m_cnt = 0; exp_valid = 1'b0; exp_data = '0;
`ifdef FIFO_ERR_EN
        m_ovf = 1'b0; m_udf = 1'b0;
`endif
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", empty); else n_pass++;
        n_checks++; if (fill_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", fill_count); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid_out); else n_pass++;
        n_checks++; if (data_out !== 10'h000) $display("FAIL reset_data got=%03h exp=000", data_out); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got ae=%0b full=%0b exp ae=1 full=0", almost_empty, full); else n_pass++;
        cycle(1'b0, 10'h0, 1'b0);
        n_checks++; if (fill_count !== 4'd0) $display("FAIL reset_nowrite got=%0d exp=0", fill_count); else n_pass++;
    endtask

    task automatic test_fill();
        th_af = 4'd6; th_ae = 4'd2;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 10'(i), 1'b0);
            n_checks++; if (fill_count !== 4'(m_cnt)) $display("FAIL fill_count got=%0d exp=%0d", fill_count, m_cnt); else n_pass++;
            n_checks++; if (almost_full !== (m_cnt >= 6)) $display("FAIL fill_af got=%0b exp=%0b at count %0d", almost_full, (m_cnt >= 6), m_cnt); else n_pass++;
            n_checks++; if (full !== (m_cnt == 8)) $display("FAIL fill_full got=%0b exp=%0b at count %0d", full, (m_cnt == 8), m_cnt); else n_pass++;
        end
        cycle(1'b1, 10'h3FF, 1'b0);
        n_checks++; if (fill_count !== 4'd8 || full !== 1'b1) $display("FAIL fill_drop got count=%0d full=%0b exp count=8 full=1", fill_count, full); else n_pass++;
`ifdef FIFO_ERR_EN
        n_checks++; if (overflow !== m_ovf) $display("FAIL overflow got=%0b exp=%0b", overflow, m_ovf); else n_pass++;
`endif
    endtask

    task automatic test_drain_wrap();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 10'h0, 1'b1);
            n_checks++; if (valid_out !== 1'b1 || data_out !== exp_data) $display("FAIL drain_data got v=%0b d=%03h exp v=1 d=%03h", valid_out, data_out, exp_data); else n_pass++;
        end
        n_checks++; if (exp_data !== 10'h008) $display("FAIL drain_last got=%03h exp=008", exp_data); else n_pass++;
        cycle(1'b0, 10'h0, 1'b0);
        n_checks++; if (valid_out !== 1'b0 || data_out !== 10'h008 || empty !== 1'b1) $display("FAIL drain_idle got v=%0b d=%03h e=%0b exp v=0 d=008 e=1", valid_out, data_out, empty); else n_pass++;
        cycle(1'b1, 10'h0AA, 1'b0);
        cycle(1'b0, 10'h0, 1'b1);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 10'h0AA) $display("FAIL wrap_data got v=%0b d=%03h exp v=1 d=0AA", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) cycle(1'b1, 10'h010 + 10'(i), 1'b0);
        cycle(1'b1, 10'h155, 1'b1);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 10'h010) $display("FAIL fullsim_data got v=%0b d=%03h exp v=1 d=010", valid_out, data_out); else n_pass++;
        n_checks++; if (fill_count !== 4'd8) $display("FAIL fullsim_count got=%0d exp=8", fill_count); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 10'h0, 1'b1);
            n_checks++; if (valid_out !== 1'b1 || data_out !== exp_data) $display("FAIL fullsim_drain got v=%0b d=%03h exp v=1 d=%03h", valid_out, data_out, exp_data); else n_pass++;
        end
        n_checks++; if (data_out !== 10'h155) $display("FAIL fullsim_last got=%03h exp=155", data_out); else n_pass++;
    endtask

    task automatic test_empty_simul();
        cycle(1'b1, 10'h2B0, 1'b1);
        n_checks++; if (valid_out !== 1'b0 || fill_count !== 4'd1) $display("FAIL emptysim got v=%0b count=%0d exp v=0 count=1", valid_out, fill_count); else n_pass++;
`ifdef FIFO_ERR_EN
        n_checks++; if (underflow !== m_udf) $display("FAIL underflow got=%0b exp=%0b", underflow, m_udf); else n_pass++;
`endif
        cycle(1'b0, 10'h0, 1'b1);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 10'h2B0) $display("FAIL emptysim_read got v=%0b d=%03h exp v=1 d=2B0", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'h040 + 10'(i), 1'b0);
        apply_reset(1);
        n_checks++; if (fill_count !== 4'd0 || empty !== 1'b1) $display("FAIL midreset got count=%0d e=%0b exp count=0 e=1", fill_count, empty); else n_pass++;
        cycle(1'b1, 10'h123, 1'b0);
        cycle(1'b0, 10'h0, 1'b1);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 10'h123) $display("FAIL midreset_read got v=%0b d=%03h exp v=1 d=123", valid_out, data_out); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL midreset_empty got=%0b exp=1", empty); else n_pass++;
    endtask

    task automatic test_thresholds();
        th_af = 4'd0; #1;
        n_checks++; if (almost_full !== 1'b1) $display("FAIL th_af0 got=%0b exp=1", almost_full); else n_pass++;
        for (int i = 0; i < 8; i++) cycle(1'b1, 10'h300 + 10'(i), 1'b0);
        th_af = 4'd9; th_ae = 4'd8; #1;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL th_af9 got=%0b exp=0", almost_full); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL th_ae8 got=%0b exp=1", almost_empty); else n_pass++;
        th_ae = 4'd7; #1;
        n_checks++; if (almost_empty !== 1'b0) $display("FAIL th_ae7 got=%0b exp=0", almost_empty); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            th_af = 4'($urandom_range(0, 9));
            th_ae = 4'($urandom_range(0, 9));
            cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            n_checks++; if (valid_out !== exp_valid || data_out !== exp_data) $display("FAIL b2b_data got v=%0b d=%03h exp v=%0b d=%03h", valid_out, data_out, exp_valid, exp_data); else n_pass++;
            n_checks++; if (fill_count !== 4'(m_cnt)) $display("FAIL b2b_count got=%0d exp=%0d", fill_count, m_cnt); else n_pass++;
            n_checks++; if (almost_full !== (m_cnt >= int'(th_af)) || almost_empty !== (m_cnt <= int'(th_ae))) $display("FAIL b2b_flags got af=%0b ae=%0b exp af=%0b ae=%0b", almost_full, almost_empty, (m_cnt >= int'(th_af)), (m_cnt <= int'(th_ae))); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_full_simul();
        test_empty_simul();
        test_mid_reset();
        test_thresholds();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
